// File: rtl/udp_frame_tx.sv
// Ethernet/IPv4/UDP frame builder streaming one byte per beat into the MAC TX interface.
// Define UDP_CHECKSUM_EN to compute the UDP checksum; otherwise the field is sent as 0x0000.
module udp_frame_tx #(
  parameter int unsigned  MAX_PAYLOAD = 32,
  parameter logic [47:0]  DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0]  SRC_MAC     = 48'h00_11_22_33_44_55,
  parameter logic [31:0]  SRC_IP      = 32'hC0_A8_01_02,
  parameter logic [31:0]  DST_IP      = 32'hC0_A8_01_03,
  parameter logic [15:0]  SRC_PORT    = 16'd5000,
  parameter logic [15:0]  DST_PORT    = 16'd6000,
  parameter logic [7:0]   IP_TTL      = 8'h40
) (
  input  logic                     tx_mac_clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [15:0]              len_i,
  input  logic [8*MAX_PAYLOAD-1:0] payload_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     tx_mac_valid_o,
  output logic [7:0]               tx_mac_data_o,
  output logic                     tx_mac_last_o,
  output logic                     tx_mac_error_o,
  input  logic                     tx_mac_ready_i
);

  localparam int unsigned PW = 8 * MAX_PAYLOAD;

  typedef enum logic [1:0] {S_IDLE, S_CSUM, S_FOLD, S_SEND} state_t;

  state_t        state_q;
  logic [15:0]   len_q, id_q, ip_csum_q, beat_q;
  logic [PW-1:0] payload_q;
  logic [6:0]    widx_q;
  logic [31:0]   ip_acc_q;
  logic          fold_q;
  logic          valid_q, last_q, error_q, busy_q, done_q, err_q;
  logic [7:0]    data_q;

  logic [15:0]   tot_len, udp_len, last_beat, nbeat, last_widx, ip_word, udp_csum_field;
  logic [31:0]   ip_fold;
  logic [335:0]  hdr, hdr_sh;
  logic [PW-1:0] pay_sh;
  logic [7:0]    nbyte;
  logic          len_ok, accept;

`ifdef UDP_CHECKSUM_EN
  logic [31:0]   udp_acc_q, udp_fold;
  logic [15:0]   udp_csum_q, udp_word, udp_c, pj, k1;
  logic [PW+7:0] pw_sh;
`endif

  assign tot_len   = len_q + 16'd28;
  assign udp_len   = len_q + 16'd8;
  assign last_beat = len_q + 16'd41;
  assign nbeat     = beat_q + 16'd1;
  assign len_ok    = (len_i != 16'd0) && (32'(len_i) <= MAX_PAYLOAD);
  assign accept    = valid_q & tx_mac_ready_i;
  assign ip_fold   = {16'd0, ip_acc_q[15:0]} + {16'd0, ip_acc_q[31:16]};

`ifdef UDP_CHECKSUM_EN
  assign last_widx      = 16'd15 + ((len_q + 16'd1) >> 1);
  assign udp_fold       = {16'd0, udp_acc_q[15:0]} + {16'd0, udp_acc_q[31:16]};
  assign udp_c          = ~udp_fold[15:0];
  assign udp_csum_field = udp_csum_q;
`else
  assign last_widx      = 16'd9;
  assign udp_csum_field = 16'h0000;
`endif

  assign hdr = {DST_MAC, SRC_MAC, 16'h0800,
                8'h45, 8'h00, tot_len, id_q, 16'h4000, IP_TTL, 8'h11, ip_csum_q,
                SRC_IP, DST_IP,
                SRC_PORT, DST_PORT, udp_len, udp_csum_field};

  // Byte for the beat after the current one; registered on acceptance.
  always_comb begin
    hdr_sh = hdr << {nbeat, 3'b000};
    pay_sh = payload_q >> {nbeat - 16'd42, 3'b000};
    nbyte  = '0;
    if (nbeat < 16'd42) nbyte = hdr_sh[335:328];
    else                nbyte = pay_sh[7:0];
  end

  always_comb begin
    ip_word = '0;
    case (widx_q)
      7'd0:    ip_word = 16'h4500;
      7'd1:    ip_word = tot_len;
      7'd2:    ip_word = id_q;
      7'd3:    ip_word = 16'h4000;
      7'd4:    ip_word = {IP_TTL, 8'h11};
      7'd6:    ip_word = SRC_IP[31:16];
      7'd7:    ip_word = SRC_IP[15:0];
      7'd8:    ip_word = DST_IP[31:16];
      7'd9:    ip_word = DST_IP[15:0];
      default: ip_word = '0;
    endcase
  end

`ifdef UDP_CHECKSUM_EN
  // Pseudo-header IP addresses share the IP header cycles 6..9; remaining words follow.
  always_comb begin
    udp_word = '0;
    pj       = {9'd0, widx_q} - 16'd16;
    pw_sh    = {8'h00, payload_q} >> {pj, 4'b0000};
    k1       = {pj[14:0], 1'b1};
    if (widx_q >= 7'd6 && widx_q <= 7'd9) udp_word = ip_word;
    else begin
      case (widx_q)
        7'd10:   udp_word = 16'h0011;
        7'd11:   udp_word = udp_len;
        7'd12:   udp_word = SRC_PORT;
        7'd13:   udp_word = DST_PORT;
        7'd14:   udp_word = udp_len;
        default: udp_word = '0;
      endcase
      if (widx_q >= 7'd16)
        udp_word = {pw_sh[7:0], (k1 < len_q) ? pw_sh[15:8] : 8'h00};
    end
  end
`endif

  always_ff @(posedge tx_mac_clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      payload_q <= '0;
      id_q      <= '0;
      widx_q    <= '0;
      ip_acc_q  <= '0;
      ip_csum_q <= '0;
      fold_q    <= 1'b0;
      beat_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UDP_CHECKSUM_EN
      udp_acc_q  <= '0;
      udp_csum_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_ok) begin
              state_q   <= S_CSUM;
              len_q     <= len_i;
              payload_q <= payload_i;
              widx_q    <= '0;
              ip_acc_q  <= '0;
              busy_q    <= 1'b1;
`ifdef UDP_CHECKSUM_EN
              udp_acc_q <= '0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CSUM: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            ip_acc_q <= ip_acc_q + {16'd0, ip_word};
`ifdef UDP_CHECKSUM_EN
            udp_acc_q <= udp_acc_q + {16'd0, udp_word};
`endif
            widx_q <= widx_q + 7'd1;
            if ({9'd0, widx_q} == last_widx) begin
              state_q <= S_FOLD;
              fold_q  <= 1'b0;
            end
          end
        end
        S_FOLD: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            ip_acc_q <= ip_fold;
`ifdef UDP_CHECKSUM_EN
            udp_acc_q <= udp_fold;
`endif
            fold_q <= 1'b1;
            if (fold_q) begin
              state_q   <= S_SEND;
              ip_csum_q <= ~ip_fold[15:0];
`ifdef UDP_CHECKSUM_EN
              udp_csum_q <= (udp_c == 16'h0000) ? 16'hFFFF : udp_c;
`endif
              beat_q  <= '0;
              valid_q <= 1'b1;
              data_q  <= DST_MAC[47:40];
              last_q  <= 1'b0;
              error_q <= 1'b0;
            end
          end
        end
        S_SEND: begin
          if (accept) begin
            if (last_q) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              error_q <= 1'b0;
              busy_q  <= 1'b0;
              id_q    <= id_q + 16'd1;
              if (error_q) err_q  <= 1'b1;
              else         done_q <= 1'b1;
            end else begin
              beat_q  <= nbeat;
              data_q  <= nbyte;
              last_q  <= (nbeat == last_beat) | abort_i;
              error_q <= abort_i;
            end
          end else if (abort_i) begin
            last_q  <= 1'b1;
            error_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign tx_mac_valid_o = valid_q;
  assign tx_mac_data_o  = data_q;
  assign tx_mac_last_o  = last_q;
  assign tx_mac_error_o = error_q;

endmodule
